// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit ripple slice, reused once per nibble under a small
// IDLE/RUN/DONE handshake FSM. Result, carry-out and signed overflow are held until consumed.
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [NIBBLES-1:0][3:0] a_q, b_q, res_q, res_nx;
  logic [KW-1:0]           k_q;
  logic                    carry_q, carry_nx;
  logic [3:0]              nib_sum;
  logic                    last;
  logic                    accept;

  // Single 4-bit ripple slice working on nibble k_q.
  always_comb begin
    logic c;
    // NOTE: every variable written here gets a value before any branch or loop,
    // otherwise synthesis infers a latch to hold the unassigned case.
    c       = carry_q;
    nib_sum = '0;
    for (int i = 0; i < 4; i++) begin
      nib_sum[i] = a_q[k_q][i] ^ b_q[k_q][i] ^ c;
      c          = (a_q[k_q][i] & b_q[k_q][i]) | (c & (a_q[k_q][i] ^ b_q[k_q][i]));
    end
    carry_nx     = c;
    res_nx       = res_q;
    res_nx[k_q]  = nib_sum;
    last         = (k_q == KW'(NIBBLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: operand and scratch registers are reset as well; they are few, and
      // this keeps every observable value defined straight out of reset.
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= cin;
        k_q     <= '0;
      end else if (state == RUN) begin
        res_q   <= res_nx;
        carry_q <= carry_nx;
        k_q     <= k_q + KW'(1);
        // Outputs change only here, on the edge that finishes the top nibble.
        if (last) begin
          sum  <= res_nx;
          cout <= carry_nx;
          ovf  <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                  (res_nx[NIBBLES-1][3] != a_q[NIBBLES-1][3]);
        end
      end
    end
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand (legal 2..8); W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operand set offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have ports a and b, input, W each, unsigned/two's-complement operands.
REQ-007 SHALL have port cin, input, 1, carry into least-significant nibble.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port sum, output, W, registered result.
REQ-011 SHALL have port cout, output, 1, carry out of most-significant nibble.
REQ-012 SHALL have port ovf, output, 1, signed overflow of the W-bit add.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; one-hot or binary encoding is free.
REQ-015 SHALL drive in_ready=1 only in IDLE; accept occurs on an edge with in_valid=1 and in_ready=1.
REQ-016 SHALL on accept latch a, b, cin into internal operand registers, clear nibble index to 0, go to RUN.
REQ-017 SHALL in RUN, each cycle, add nibble k of a, nibble k of b and the carry register with one 4-bit ripple datapath (four full-adder slices), write 4-bit result into nibble k of the internal result register, update carry register, increment k.
REQ-018 SHALL use latched cin as the carry for k=0 and the previous nibble's carry-out for k>0.
REQ-019 SHALL, on the edge processing k=NIBBLES-1, load sum from the completed result, cout from the final carry, ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), and go to DONE.
REQ-020 SHALL have latency: accept at edge T, out_valid high after edge T+NIBBLES (NIBBLES RUN cycles).
REQ-021 SHALL assert out_valid only in DONE; sum, cout, ovf SHALL hold stable while out_valid=1.
REQ-022 SHALL on an edge in DONE with out_ready=1 drop out_valid and return to IDLE; throughput one add per NIBBLES+2 cycles.
REQ-023 SHALL hold DONE indefinitely while out_ready=0 (backpressure); no new operands accepted.
REQ-024 SHALL ignore in_valid, a, b, cin changes outside IDLE; operand registers unchanged in RUN/DONE.
REQ-025 SHALL keep sum, cout, ovf at previous result values in IDLE and RUN; they change only on the REQ-019 edge.
REQ-026 SHALL wrap modulo 2^W; carry beyond bit W-1 appears only on cout.
REQ-027 SHALL treat out_ready asserted before DONE as don't-care.

Reset
REQ-028 SHALL, on rst=1, immediately and asynchronously enter IDLE with in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, nibble index 0, carry register 0.
REQ-029 SHALL abort any in-progress RUN or DONE on reset; no partial result is ever presented.
REQ-030 SHALL accept new operands on the first edge after rst deasserts if in_valid=1.

Verification
REQ-031 NIBBLES=4: a=0x1234, b=0x4321, cin=0 -> after 4 RUN cycles sum=0x5555, cout=0, ovf=0, out_valid=1.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibbles).
REQ-033 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0.
REQ-034 Backpressure: result ready, out_ready=0 for 3 cycles then 1 -> out_valid high 4 cycles, sum constant, in_ready=0 throughout, IDLE next cycle.
REQ-035 Reset mid-RUN at k=2 -> same cycle out_valid=0, sum=0, in_ready=1; next accepted add completes correctly with no stale carry.
REQ-036 Back-to-back with in_valid held high and out_ready=1 -> accept every 6 cycles, results match reference model for 1000 random operand sets.
